// File: rtl/snake_pkg.sv
// Shared direction encoding and helpers for the Snake game front end.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  localparam dir_t DIR_RESET = DIR_RIGHT;

  function automatic dir_t dir_opposite(input dir_t d);
    return dir_t'(d ^ 2'd2);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stable-count debouncer and one-cycle press pulse
// for a single raw button.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  always_comb begin
    sync_d  = {sync_q[0], btn};
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Level flips on the DEB_CYCLES-th consecutive differing sample.
      cnt_d   = '0;
      level_d = ~level_q;
      press_d = ~level_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/dir_ctrl.sv
// Direction-input front end: debounced buttons, reversal filtering and a
// pending-turn buffer. Define DIR_QUEUE_EN for a QUEUE_DEPTH-entry FIFO;
// otherwise a single last-wins slot is used.
module dir_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 250000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       right,
  input  logic       down,
  input  logic       left,
  input  logic       tick,
  output logic [1:0] dir,
  output logic       turn,
  output logic [2:0] pending
);

  if (QUEUE_DEPTH < 2 || QUEUE_DEPTH > 7) begin : g_bad_depth
    $error("dir_ctrl: QUEUE_DEPTH must be 2..7");
  end

  logic [3:0] press_vec;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up    (.clk(clk), .rst(rst), .btn(up),    .press(press_vec[0]));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (.clk(clk), .rst(rst), .btn(right), .press(press_vec[1]));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down  (.clk(clk), .rst(rst), .btn(down),  .press(press_vec[2]));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left  (.clk(clk), .rst(rst), .btn(left),  .press(press_vec[3]));

  logic press_any;
  dir_t press_dir;
  dir_t dir_q, dir_d;
  logic turn_q, turn_d;
  logic pop;
  dir_t ref_dir;
  logic press_ok;

  always_comb begin
    press_any = |press_vec;
    if (press_vec[0])      press_dir = DIR_UP;
    else if (press_vec[1]) press_dir = DIR_RIGHT;
    else if (press_vec[2]) press_dir = DIR_DOWN;
    else                   press_dir = DIR_LEFT;
  end

  assign press_ok = press_any && (press_dir != ref_dir) && (press_dir != dir_opposite(ref_dir));

`ifdef DIR_QUEUE_EN
  localparam int unsigned PTR_W   = $clog2(QUEUE_DEPTH);
  localparam int unsigned MEM_N   = 1 << PTR_W;
  localparam logic [2:0]  DEPTH_C = 3'(QUEUE_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);

  dir_t             mem_q [MEM_N];
  dir_t             mem_d [MEM_N];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, tail_idx;
  logic [2:0]       count_q, count_d, count_post;
  logic             push;

  always_comb begin
    pop        = tick && (count_q != 3'd0);
    dir_d      = pop ? mem_q[rd_ptr_q] : dir_q;
    turn_d     = pop;
    count_post = count_q - {2'b00, pop};
    tail_idx   = (wr_ptr_q == '0) ? PTR_LAST : wr_ptr_q - 1'b1;
    // Reference is the newest still-buffered turn, or the post-pop dir.
    ref_dir    = (count_post != 3'd0) ? mem_q[tail_idx] : dir_d;
    push       = press_ok && (count_post < DEPTH_C);

    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = press_dir;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    count_d = count_post + {2'b00, push};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < MEM_N; i++) mem_q[i] <= DIR_RESET;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pending = count_q;
`else
  dir_t slot_q, slot_d;
  logic slot_valid_q, slot_valid_d;

  always_comb begin
    pop          = tick && slot_valid_q;
    dir_d        = pop ? slot_q : dir_q;
    turn_d       = pop;
    ref_dir      = dir_d;
    slot_d       = press_ok ? press_dir : slot_q;
    slot_valid_d = press_ok || (slot_valid_q && !pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q       <= DIR_RESET;
      slot_valid_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      slot_valid_q <= slot_valid_d;
    end
  end

  assign pending = {2'b00, slot_valid_q};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q  <= DIR_RESET;
      turn_q <= 1'b0;
    end else begin
      dir_q  <= dir_d;
      turn_q <= turn_d;
    end
  end

  assign dir  = dir_q;
  assign turn = turn_q;

endmodule
